// File: rtl/uart_frame_deframer.sv
// Frame deframer behind the UART receiver: hunts SYNC, checks LEN/CSUM, buffers the payload
// and releases it on a valid/ready stream only once the whole command has verified.
module uart_frame_deframer #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2048
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  input  logic       rx_error,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [2:0] err_code,
  output logic       busy
);

  localparam int unsigned LW    = $clog2(MAX_LEN + 1);
  localparam int unsigned AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned Depth = 1 << AW;
  localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES);
  // Fires on the edge where the counter would reach TIMEOUT_CYCLES-1.
  localparam logic [TW-1:0] TmoFire = TW'(TIMEOUT_CYCLES - 2);

  localparam logic [2:0] ErrTimeout = 3'd0;
  localparam logic [2:0] ErrLen     = 3'd1;
  localparam logic [2:0] ErrCsum    = 3'd2;
  localparam logic [2:0] ErrLine    = 3'd3;
  localparam logic [2:0] ErrOverrun = 3'd4;

  typedef enum logic [2:0] {StHunt, StLen, StPayload, StCsum, StEmit} state_e;

  state_e        state_q, state_d;
  logic          rdy_q;
  logic [LW-1:0] len_q, len_d, idx_q, idx_d;
  logic [7:0]    csum_q, csum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    m_data_q, m_data_d;
  logic          m_valid_q, m_valid_d;
  logic          m_last_q, m_last_d;
  logic          frame_ok_q, frame_ok_d;
  logic          frame_err_q, frame_err_d;
  logic [2:0]    err_code_q, err_code_d;
  logic [7:0]    buf_q [Depth];

  logic          byte_ev, in_frame, timeout, wr_en, err_set;
  logic [2:0]    err_val;
  logic [LW-1:0] last_idx, nxt_idx;

  assign byte_ev  = rx_ready & ~rdy_q;
  assign in_frame = (state_q == StLen) || (state_q == StPayload) || (state_q == StCsum);
  assign timeout  = in_frame && !byte_ev && (tmo_q == TmoFire);
  assign last_idx = len_q - LW'(1);
  assign nxt_idx  = idx_q + LW'(1);

  always_comb begin
    tmo_d = tmo_q;
    if (byte_ev || !in_frame) begin
      tmo_d = '0;
    end else if (tmo_q != '1) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    wr_en       = 1'b0;
    err_set     = 1'b0;
    err_val     = ErrTimeout;

    unique case (state_q)
      StHunt: begin
        if (byte_ev && !rx_error && rx_data == SYNC_BYTE) state_d = StLen;
      end
      StLen: begin
        if (byte_ev) begin
          if (rx_error) begin
            err_set = 1'b1;
            err_val = ErrLine;
          end else if (rx_data == 8'd0 || 32'(rx_data) > MAX_LEN) begin
            err_set = 1'b1;
            err_val = ErrLen;
          end else begin
            len_d   = rx_data[LW-1:0];
            csum_d  = rx_data;
            idx_d   = '0;
            state_d = StPayload;
          end
        end
      end
      StPayload: begin
        if (byte_ev) begin
          if (rx_error) begin
            err_set = 1'b1;
            err_val = ErrLine;
          end else begin
            wr_en  = 1'b1;
            csum_d = csum_q ^ rx_data;
            idx_d  = nxt_idx;
            if (idx_q == last_idx) state_d = StCsum;
          end
        end
      end
      StCsum: begin
        if (byte_ev) begin
          if (rx_error) begin
            err_set = 1'b1;
            err_val = ErrLine;
          end else if (rx_data == csum_q) begin
            frame_ok_d = 1'b1;
            idx_d      = '0;
            state_d    = StEmit;
          end else begin
            err_set = 1'b1;
            err_val = ErrCsum;
          end
        end
      end
      StEmit: begin
        // Overrun is reported but never disturbs the frame being released.
        if (byte_ev) begin
          frame_err_d = 1'b1;
          err_code_d  = ErrOverrun;
        end
        if (!m_valid_q) begin
          m_valid_d = 1'b1;
          m_data_d  = buf_q[idx_q[AW-1:0]];
          m_last_d  = (idx_q == last_idx);
        end else if (m_ready) begin
          if (m_last_q) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            state_d   = StHunt;
          end else begin
            idx_d    = nxt_idx;
            m_data_d = buf_q[nxt_idx[AW-1:0]];
            m_last_d = (nxt_idx == last_idx);
          end
        end
      end
      default: state_d = StHunt;
    endcase

    if (timeout) begin
      err_set = 1'b1;
      err_val = ErrTimeout;
    end
    if (err_set) begin
      frame_err_d = 1'b1;
      err_code_d  = err_val;
      state_d     = StHunt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StHunt;
      rdy_q       <= 1'b1;
      len_q       <= '0;
      idx_q       <= '0;
      csum_q      <= '0;
      tmo_q       <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rx_ready;
      len_q       <= len_d;
      idx_q       <= idx_d;
      csum_q      <= csum_d;
      tmo_q       <= tmo_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) buf_q[idx_q[AW-1:0]] <= rx_data;
  end

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign busy      = (state_q != StHunt);

endmodule

// File: tb/tb_uart_frame_deframer.sv
// Bench for uart_frame_deframer: directed scenarios plus random frames, each checked against a
// byte-stream parser model of the framing rules.
module tb_uart_frame_deframer;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int MAXL = 16;
  localparam int TMO  = 2048;

  logic       clk = 1'b0;
  logic       rst_n, rx_ready, rx_error, m_ready, m_valid, m_last, frame_ok, frame_err, busy;
  logic [7:0] rx_data, m_data;
  logic [2:0] err_code;

  always #5 clk = ~clk;

  uart_frame_deframer #(
    .SYNC_BYTE     (SYNC),
    .MAX_LEN       (MAXL),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .rx_error (rx_error),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .err_code (err_code),
    .busy     (busy)
  );

  int total = 0;
  int bad   = 0;
  int rdy_mode = 0;

  int neg_n = 0, ok_cnt = 0, ok_n = 0, valid_cnt = 0, hold_viol = 0, last_ev_n = 0, err_n = 0;
  logic [8:0] got_q[$];
  int         xfer_n[$];
  int         err_q[$];

  logic [7:0] tx_d[$];
  bit         tx_e[$];
  int         exp_err[$];
  logic [8:0] exp_pl[$];
  int         exp_ok;

  // Downstream ready pattern: 0 always, 1 random, 2 toggling, 3 stalled.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: m_ready = 1'b1;
        1: m_ready = 1'($urandom % 2);
        2: m_ready = ~m_ready;
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Monitor, sampled mid-cycle.
  initial begin
    logic mon_prev, pv, pr, pl;
    logic [7:0] pd;
    mon_prev = 1'b1; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = 8'h00;
    forever begin
      @(negedge clk);
      neg_n++;
      if (!rst_n) begin
        mon_prev = 1'b1;
        pv = 1'b0;
      end else begin
        if (rx_ready && !mon_prev) last_ev_n = neg_n;
        mon_prev = rx_ready;
        if (m_valid) valid_cnt++;
        if (pv && !pr && !(m_valid && m_data == pd && m_last == pl)) hold_viol++;
        pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
        if (m_valid && m_ready) begin
          got_q.push_back({m_last, m_data});
          xfer_n.push_back(neg_n);
        end
        if (frame_ok) begin
          ok_cnt++;
          ok_n = neg_n;
        end
        if (frame_err) begin
          err_q.push_back(int'(err_code));
          err_n = neg_n;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    got_q.delete(); xfer_n.delete(); err_q.delete();
    ok_cnt = 0; valid_cnt = 0; hold_viol = 0;
  endtask

  task automatic clear_tx();
    tx_d.delete(); tx_e.delete();
  endtask

  task automatic put(input logic [7:0] b, input bit e);
    tx_d.push_back(b);
    tx_e.push_back(e);
  endtask

  // Frame builder; err_pos: -1 none, 0 LEN byte, 1..len payload byte, len+1 checksum byte.
  task automatic add_frame(input int len, input logic [7:0] cs_flip, input int err_pos);
    logic [7:0] cs, b;
    put(SYNC, 1'b0);
    if (err_pos == 0) begin
      put(8'(len), 1'b1);
      return;
    end
    put(8'(len), 1'b0);
    cs = 8'(len);
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom);
      if (err_pos == k + 1) begin
        put(b, 1'b1);
        return;
      end
      put(b, 1'b0);
      cs = cs ^ b;
    end
    if (err_pos == len + 1) begin
      put(cs, 1'b1);
      return;
    end
    put(cs ^ cs_flip, 1'b0);
  endtask

  // Parses the transmitted byte list by the framing rules; a frame cut short ends in a timeout.
  function automatic void model();
    int i, n, len;
    logic [7:0] cs;
    logic [7:0] pl[$];
    bit cut;
    logic lastb;
    exp_err.delete(); exp_pl.delete(); exp_ok = 0;
    n = tx_d.size();
    i = 0;
    while (i < n) begin
      if (tx_e[i] || tx_d[i] != SYNC) begin
        i++;
        continue;
      end
      i++;
      if (i >= n) begin exp_err.push_back(0); return; end
      if (tx_e[i]) begin exp_err.push_back(3); i++; continue; end
      len = int'(tx_d[i]);
      i++;
      if (len == 0 || len > MAXL) begin exp_err.push_back(1); continue; end
      pl.delete();
      cut = 1'b0;
      for (int k = 0; k < len; k++) begin
        if (i >= n) begin exp_err.push_back(0); return; end
        if (tx_e[i]) begin cut = 1'b1; i++; break; end
        pl.push_back(tx_d[i]);
        i++;
      end
      if (cut) begin exp_err.push_back(3); continue; end
      if (i >= n) begin exp_err.push_back(0); return; end
      cs = 8'(len);
      foreach (pl[k]) cs = cs ^ pl[k];
      if (tx_e[i]) exp_err.push_back(3);
      else if (tx_d[i] != cs) exp_err.push_back(2);
      else begin
        exp_ok++;
        foreach (pl[k]) begin
          lastb = (k == len - 1);
          exp_pl.push_back({lastb, pl[k]});
        end
      end
      i++;
    end
  endfunction

  task automatic send_byte(input logic [7:0] d, input bit e);
    @(posedge clk);
    #1;
    rx_data = d; rx_error = e; rx_ready = 1'b1;
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1;
    rx_ready = 1'b0; rx_error = 1'b0;
    repeat ($urandom_range(1, 6)) @(posedge clk);
  endtask

  task automatic send_stream();
    for (int k = 0; k < tx_d.size(); k++) send_byte(tx_d[k], tx_e[k]);
  endtask

  task automatic wait_idle(input string tag);
    int q, n;
    q = 0; n = 0;
    while (q < 2 && n < 5000) begin
      @(negedge clk);
      n++;
      if (!busy && !m_valid) q++;
      else q = 0;
    end
    total++;
    assert (q >= 2) else begin
      bad++;
      $error("FAIL %s/idle: observed=still busy expected=idle within 5000 cycles", tag);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "/n_err"}, err_q.size(), exp_err.size());
    for (int k = 0; k < exp_err.size() && k < err_q.size(); k++)
      chk({tag, "/err_code"}, err_q[k], exp_err[k]);
    chk({tag, "/n_ok"}, ok_cnt, exp_ok);
    chk({tag, "/n_bytes"}, got_q.size(), exp_pl.size());
    for (int k = 0; k < exp_pl.size() && k < got_q.size(); k++)
      chk({tag, "/byte"}, got_q[k], exp_pl[k]);
    chk({tag, "/hold"}, hold_viol, 0);
  endtask

  task automatic run_stream(input string tag);
    clear_mon();
    model();
    send_stream();
    wait_idle(tag);
    compare_all(tag);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!m_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "/valid_seen"}, m_valid, 1'b1);
  endtask

  initial begin
    int kind, len, pos;
    logic [7:0] b;

    rst_n = 1'b0; rx_ready = 1'b1; rx_data = SYNC; rx_error = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst/m_valid", m_valid, 1'b0);
    chk("rst/m_last", m_last, 1'b0);
    chk("rst/frame_ok", frame_ok, 1'b0);
    chk("rst/frame_err", frame_err, 1'b0);
    chk("rst/busy", busy, 1'b0);
    chk("rst/err_code", err_code, 3'd0);
    chk("rst/m_data", m_data, 8'h00);
    // Ready already high at release must not count as a SYNC byte.
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst/stale_ready", busy, 1'b0);
    rx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Good frame with the downstream always ready.
    rdy_mode = 0;
    clear_tx();
    put(8'hA5, 0); put(8'h03, 0); put(8'h11, 0); put(8'h22, 0); put(8'h33, 0); put(8'h03, 0);
    run_stream("good3");
    chk("good3/n_xfer", xfer_n.size(), 3);
    if (xfer_n.size() == 3) begin
      chk("good3/b2_after_b1", xfer_n[1] - xfer_n[0], 1);
      chk("good3/b3_after_b2", xfer_n[2] - xfer_n[1], 1);
      chk("good3/valid_latency", xfer_n[0] - ok_n, 1);
      chk("good3/last_byte", got_q[2], {1'b1, 8'h33});
      chk("good3/first_byte", got_q[0], {1'b0, 8'h11});
    end

    // Bad checksum.
    clear_tx();
    put(8'hA5, 0); put(8'h03, 0); put(8'h11, 0); put(8'h22, 0); put(8'h33, 0); put(8'h04, 0);
    run_stream("badcsum");
    chk("badcsum/no_valid", valid_cnt, 0);
    chk("badcsum/busy", busy, 1'b0);
    chk("badcsum/code", err_code, 3'd2);

    // Zero and oversize length, then a valid frame.
    clear_tx();
    put(8'hA5, 0); put(8'h00, 0);
    put(8'hA5, 0); put(8'h11, 0);
    put(8'hA5, 0); put(8'h02, 0); put(8'h5A, 0); put(8'hC3, 0); put(8'h02 ^ 8'h5A ^ 8'hC3, 0);
    run_stream("badlen");

    // Silence mid-frame: error TIMEOUT-1 cycles after the edge that took the 7E byte.
    clear_tx();
    put(8'hA5, 0); put(8'h02, 0); put(8'h7E, 0);
    run_stream("timeout");
    chk("timeout/delay", err_n - last_ev_n, 1 + (TMO - 1));

    // Line error mid-payload.
    clear_tx();
    put(8'hA5, 0); put(8'h03, 0); put(8'h11, 0); put(8'h22, 1);
    run_stream("line_err");

    // SYNC carrying a line error while hunting is ignored.
    clear_tx();
    clear_mon();
    put(8'hA5, 1);
    model();
    send_stream();
    chk("hunt_err/busy", busy, 1'b0);
    wait_idle("hunt_err");
    compare_all("hunt_err");

    // Overrun during a stalled EMIT, then toggling ready.
    clear_tx();
    clear_mon();
    add_frame(4, 8'h00, -1);
    model();
    exp_err.push_back(4);
    rdy_mode = 3;
    send_stream();
    wait_valid("overrun");
    send_byte(8'h3C, 1'b0);
    rdy_mode = 2;
    wait_idle("overrun");
    compare_all("overrun");

    // Reset in the middle of EMIT clears the stream at once.
    clear_tx();
    clear_mon();
    add_frame(5, 8'h00, -1);
    rdy_mode = 3;
    send_stream();
    wait_valid("rst_emit");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_emit/m_valid", m_valid, 1'b0);
    chk("rst_emit/m_last", m_last, 1'b0);
    chk("rst_emit/busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy_mode = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_emit/stays_idle", m_valid, 1'b0);

    // Random frames with noise prefixes.
    for (int f = 0; f < 25; f++) begin
      clear_tx();
      repeat ($urandom_range(0, 2)) begin
        if ($urandom % 2 == 0) put(SYNC, 1'b1);
        else begin
          b = 8'($urandom);
          if (b == SYNC) b = 8'h00;
          put(b, 1'($urandom % 2));
        end
      end
      kind = $urandom_range(0, 4);
      len  = $urandom_range(1, MAXL);
      rdy_mode = $urandom_range(0, 1);
      case (kind)
        0, 1: add_frame(len, 8'h00, -1);
        2: add_frame(len, 8'($urandom_range(1, 255)), -1);
        3: begin
          put(SYNC, 1'b0);
          if ($urandom % 2 == 0) put(8'h00, 1'b0);
          else put(8'($urandom_range(MAXL + 1, 255)), 1'b0);
        end
        default: begin
          pos = $urandom_range(0, len + 1);
          add_frame(len, 8'h00, pos);
        end
      endcase
      run_stream("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
